// File: rtl/avalon_pio_edge_in_if.sv
// avalon_pio_edge_in_if: Avalon-MM slave bus and interrupt line for the input PIO.
interface avalon_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/avalon_pio_edge_in.sv
// avalon_pio_edge_in: input PIO with synchronizer, sticky edge capture and maskable irq.
// Optional debounce filter enabled by defining PIO_DEBOUNCE_EN.
module avalon_pio_edge_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  avalon_pio_edge_in_if.slave  bus
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] w_level, r_prev, r_mask, r_cap, w_rise, w_fall, w_edge, w_clr;
  logic             r_irq, w_wr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0]         r_filt;
  // Filtered value only follows the synced pin after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt  <= '0;
      r_filt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (r_sync[SYNC_STAGES-1][i] == r_filt[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] + CW'(1) == CW'(DEBOUNCE_CYCLES)) begin
          r_cnt[i]  <= '0;
          r_filt[i] <= r_sync[SYNC_STAGES-1][i];
        end else r_cnt[i] <= r_cnt[i] + CW'(1);
    end
  assign w_level = r_filt;
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif
  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;
  assign w_edge = EDGE_TYPE == 0 ? w_rise : EDGE_TYPE == 1 ? w_fall : (w_rise | w_fall);
  assign w_wr   = bus.chipselect && !bus.write_n;
  assign w_clr  = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  // A new edge wins over a write-1-to-clear of the same bit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_prev <= '0;
      r_mask <= '0;
      r_cap  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_level;
      if (w_wr && bus.address == 2'd2) r_mask <= bus.writedata[WIDTH-1:0];
      r_cap  <= (r_cap & ~w_clr) | w_edge;
      r_irq  <= |(r_cap & r_mask);
    end
  assign bus.readdata = bus.address == 2'd0 ? 32'(w_level) :
                        bus.address == 2'd2 ? 32'(r_mask) :
                        bus.address == 2'd3 ? 32'(r_cap) : 32'd0;
  assign bus.irq = r_irq;
endmodule

// File: tb/tb_avalon_pio_edge_in.sv
// tb_avalon_pio_edge_in: directed table plus hand sequences for the input PIO.
module tb_avalon_pio_edge_in;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] in_port = '0, in_port2 = '0;
  int n_cmp = 0, n_bad = 0;
  avalon_pio_edge_in_if bus(), bus2();
  avalon_pio_edge_in #(.WIDTH(4), .EDGE_TYPE(0)) dut (.clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus));
  avalon_pio_edge_in #(.WIDTH(4), .EDGE_TYPE(2)) dut2 (.clk(clk), .reset_n(reset_n), .in_port(in_port2), .bus(bus2));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [3:0]  pin;
    logic        wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    int          n;
    logic [31:0] e_data, e_mask, e_cap;
    logic        e_irq;
  } vec_t;
  vec_t tbl[16];
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask
  task automatic rd2(input logic [1:0] a, output logic [31:0] d);
    bus2.address = a;
    #1;
    d = bus2.readdata;
  endtask
  task automatic wr_start(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
  endtask
  task automatic wr_stop();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask
  task automatic chk_all(input string nm, input logic [31:0] ed, em, ec, input logic ei);
    logic [31:0] d;
    rd(2'd0, d); chk({nm, " DATA"}, d, ed);
    rd(2'd2, d); chk({nm, " IRQMASK"}, d, em);
    rd(2'd3, d); chk({nm, " EDGECAP"}, d, ec);
    chk({nm, " irq"}, {31'd0, bus.irq}, {31'd0, ei});
  endtask
  initial begin
    logic [31:0] d;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    // name, pin, wr, wa, wd, ticks, DATA, IRQMASK, EDGECAP, irq
    tbl[0]  = '{"reset",        4'h0, 1'b0, 2'd0, 32'h0,        2, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{"mask5",        4'h0, 1'b1, 2'd2, 32'h5,        1, 32'h0, 32'h5, 32'h0, 1'b0};
    tbl[2]  = '{"b0 level N+1", 4'h1, 1'b0, 2'd0, 32'h0,        2, 32'h1, 32'h5, 32'h0, 1'b0};
    tbl[3]  = '{"b0 cap N+2",   4'h1, 1'b0, 2'd0, 32'h0,        1, 32'h1, 32'h5, 32'h1, 1'b0};
    tbl[4]  = '{"b0 irq N+3",   4'h1, 1'b0, 2'd0, 32'h0,        1, 32'h1, 32'h5, 32'h1, 1'b1};
    tbl[5]  = '{"clr b0",       4'h1, 1'b1, 2'd3, 32'h1,        1, 32'h1, 32'h5, 32'h0, 1'b1};
    tbl[6]  = '{"irq drops",    4'h1, 1'b0, 2'd0, 32'h0,        1, 32'h1, 32'h5, 32'h0, 1'b0};
    tbl[7]  = '{"b1 masked",    4'h3, 1'b0, 2'd0, 32'h0,        3, 32'h3, 32'h5, 32'h2, 1'b0};
    tbl[8]  = '{"b1 no irq",    4'h3, 1'b0, 2'd0, 32'h0,        2, 32'h3, 32'h5, 32'h2, 1'b0};
    tbl[9]  = '{"unmask b1",    4'h3, 1'b1, 2'd2, 32'h2,        1, 32'h3, 32'h2, 32'h2, 1'b0};
    tbl[10] = '{"unmask irq",   4'h3, 1'b0, 2'd0, 32'h0,        1, 32'h3, 32'h2, 32'h2, 1'b1};
    tbl[11] = '{"wr DATA ign",  4'h3, 1'b1, 2'd0, 32'hF,        1, 32'h3, 32'h2, 32'h2, 1'b1};
    tbl[12] = '{"wr rsvd ign",  4'h3, 1'b1, 2'd1, 32'hF,        1, 32'h3, 32'h2, 32'h2, 1'b1};
    tbl[13] = '{"clr all",      4'h3, 1'b1, 2'd3, 32'hFFFFFFFF, 2, 32'h3, 32'h2, 32'h0, 1'b0};
    tbl[14] = '{"fall ignored", 4'h0, 1'b0, 2'd0, 32'h0,        4, 32'h0, 32'h2, 32'h0, 1'b0};
    tbl[15] = '{"mask upper",   4'h0, 1'b1, 2'd2, 32'hFFFFFFF0, 1, 32'h0, 32'h0, 32'h0, 1'b0};
    tick(2);
    chk_all("in reset", 32'h0, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b1;
`ifndef PIO_DEBOUNCE_EN
    foreach (tbl[k]) begin
      in_port = tbl[k].pin;
      if (tbl[k].wr) wr_start(tbl[k].wa, tbl[k].wd);
      tick();
      wr_stop();
      tick(tbl[k].n - 1);
      chk_all(tbl[k].name, tbl[k].e_data, tbl[k].e_mask, tbl[k].e_cap, tbl[k].e_irq);
    end
    rd(2'd1, d); chk("reserved reads 0", d, 32'h0);
    // Clear of bit2 and new rise on bit0 in the same write cycle
    wr_start(2'd2, 32'h1); tick(); wr_stop();
    in_port = 4'h4; tick(3);
    rd(2'd3, d); chk("b2 captured", d, 32'h4);
    in_port = 4'h5; tick(2);
    wr_start(2'd3, 32'h5); tick(); wr_stop();
    rd(2'd3, d); chk("set wins clr", d, 32'h1);
    tick();
    chk("set wins irq", {31'd0, bus.irq}, 32'h1);
    // Asynchronous reset while irq is high
    reset_n = 1'b0;
    #1;
    chk("async irq drop", {31'd0, bus.irq}, 32'h0);
    rd(2'd3, d); chk("async cap clr", d, 32'h0);
    in_port = 4'h0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk_all("post reset", 32'h0, 32'h0, 32'h0, 1'b0);
    // Any-edge instance: rise then fall on bit3, 10 clocks apart
    in_port2 = 4'h8; tick(3);
    rd2(2'd3, d); chk("any rise cap", d, 32'h8);
    bus2.chipselect = 1'b1; bus2.write_n = 1'b0; bus2.address = 2'd3; bus2.writedata = 32'h8;
    tick();
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    rd2(2'd3, d); chk("any cleared", d, 32'h0);
    tick(6);
    in_port2 = 4'h0; tick(2);
    rd2(2'd3, d); chk("any fall early", d, 32'h0);
    tick();
    rd2(2'd3, d); chk("any fall cap", d, 32'h8);
    rd2(2'd0, d); chk("any data low", d, 32'h0);
`else
    tick(2);
    in_port = 4'h1; tick(5);
    in_port = 4'h0; tick(30);
    rd(2'd0, d); chk("deb pulse data", d, 32'h0);
    rd(2'd3, d); chk("deb pulse cap", d, 32'h0);
    in_port = 4'h1; tick(17);
    rd(2'd0, d); chk("deb t17 data", d, 32'h0);
    tick();
    rd(2'd0, d); chk("deb t18 data", d, 32'h1);
    rd(2'd3, d); chk("deb t18 cap", d, 32'h0);
    tick();
    rd(2'd3, d); chk("deb t19 cap", d, 32'h1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
